// File: rtl/brute_force_matcher_perf_counter_bank.sv
// Multi-channel start/stop performance counter bank for the brute-force matcher.
// Each channel counts cycles or qualified events, saturates, and exposes its capture via a registered readout.
module brute_force_matcher_perf_counter_bank #(
  parameter int                NUM_CH     = 4,
  parameter int                CNT_W      = 32,
  parameter int                SEL_W      = 2,
  parameter logic [NUM_CH-1:0] EVENT_MODE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              initialize,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  input  logic [NUM_CH-1:0] evt,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_sat,
  output logic              rd_done,
  output logic [NUM_CH-1:0] done,
  output logic              all_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q [NUM_CH];
  state_e             state_d [NUM_CH];
  logic [CNT_W-1:0]   cnt_q   [NUM_CH];
  logic [CNT_W-1:0]   cnt_d   [NUM_CH];
  logic [CNT_W-1:0]   cap_q   [NUM_CH];
  logic [CNT_W-1:0]   cap_d   [NUM_CH];
  logic [CNT_W-1:0]   cnt_inc [NUM_CH];
  logic [NUM_CH-1:0]  sat_q, sat_d;
  logic [NUM_CH-1:0]  inc;
  logic [NUM_CH-1:0]  at_max;

  logic [CNT_W-1:0]   rd_data_q, rd_data_d;
  logic               rd_sat_q, rd_sat_d;
  logic               rd_done_q, rd_done_d;

  // Saturating increment: a full counter stays at all-ones instead of wrapping.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      inc[i]     = EVENT_MODE[i] ? evt[i] : 1'b1;
      at_max[i]  = &cnt_q[i];
      cnt_inc[i] = (inc[i] && at_max[i]) ? cnt_q[i] : cnt_q[i] + CNT_W'(inc[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      cap_d[i]   = cap_q[i];
      sat_d[i]   = sat_q[i];

      if (!enable) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else if (initialize) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
        sat_d[i]   = 1'b0;
      end else begin
        unique case (state_q[i])
          ST_IDLE: begin
            if (start[i]) begin
              state_d[i] = ST_RUN;
              cnt_d[i]   = '0;
            end
          end
          ST_RUN: begin
            cnt_d[i] = cnt_inc[i];
            if (inc[i] && at_max[i]) sat_d[i] = 1'b1;
            // The stop cycle itself is counted, so capture the incremented value.
            if (stop[i]) begin
              cap_d[i]   = cnt_inc[i];
              state_d[i] = ST_DONE;
            end
          end
          ST_DONE: ;
          default: state_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  // Readout samples next-state values so a capture in the current cycle is visible immediately.
  always_comb begin
    rd_data_d = '0;
    rd_sat_d  = 1'b0;
    rd_done_d = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_data_d = cap_d[i];
        rd_sat_d  = sat_d[i];
        rd_done_d = (state_d[i] == ST_DONE);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      // NOTE: the per-channel arrays are small flop banks, so they are reset like any other register.
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        cap_q[i]   <= '0;
      end
      sat_q     <= '0;
      rd_data_q <= '0;
      rd_sat_q  <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        cap_q[i]   <= cap_d[i];
      end
      sat_q     <= sat_d;
      rd_data_q <= rd_data_d;
      rd_sat_q  <= rd_sat_d;
      rd_done_q <= rd_done_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      done[i] = (state_q[i] == ST_DONE);
    end
  end

  assign all_done = &done;
  assign rd_data  = rd_data_q;
  assign rd_sat   = rd_sat_q;
  assign rd_done  = rd_done_q;

endmodule

// File: tb/tb_brute_force_matcher_perf_counter_bank.sv
// Directed bench: a 4-channel 8-bit bank (channel 1 in event mode) plus a 3-channel bank for out-of-range reads.
module tb_brute_force_matcher_perf_counter_bank;

  logic       clk = 1'b0;
  logic       rst, enable, initialize;
  logic [3:0] start, stop, evt;
  logic [1:0] rd_sel;
  logic [7:0] rd_data, rd_data3;
  logic       rd_sat, rd_done, rd_sat3, rd_done3;
  logic [3:0] done;
  logic [2:0] done3;
  logic       all_done, all_done3;

  int n_checks = 0;
  int n_errors = 0;

  brute_force_matcher_perf_counter_bank #(
    .NUM_CH(4), .CNT_W(8), .SEL_W(2), .EVENT_MODE(4'b0010)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .initialize(initialize),
    .start(start), .stop(stop), .evt(evt), .rd_sel(rd_sel),
    .rd_data(rd_data), .rd_sat(rd_sat), .rd_done(rd_done),
    .done(done), .all_done(all_done)
  );

  brute_force_matcher_perf_counter_bank #(
    .NUM_CH(3), .CNT_W(8), .SEL_W(2), .EVENT_MODE(3'b000)
  ) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .initialize(initialize),
    .start(start[2:0]), .stop(stop[2:0]), .evt(evt[2:0]), .rd_sel(rd_sel),
    .rd_data(rd_data3), .rd_sat(rd_sat3), .rd_done(rd_done3),
    .done(done3), .all_done(all_done3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    int          n;
    logic [31:0] pat;
    logic [7:0]  exp_data;
  } meas_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] exp_data;
    logic [7:0] exp_data3;
    logic       exp_done3;
  } sweep_t;

  meas_t  meas [3];
  sweep_t sweep [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start pulse, then n cycles with the stop on the n-th; evt follows pat bit k-1 in cycle k.
  task automatic run_measure(input int ch, input int n, input logic [31:0] pat);
    start[ch] = 1'b1;
    rd_sel    = 2'(ch);
    tick();
    start[ch] = 1'b0;
    for (int k = 1; k <= n; k++) begin
      evt[ch]  = (k <= 32) ? pat[k-1] : 1'b0;
      stop[ch] = (k == n);
      tick();
    end
    stop[ch] = 1'b0;
    evt[ch]  = 1'b0;
  endtask

  initial begin
    meas[0] = '{ch: 0, n: 15, pat: 32'h0,         exp_data: 8'd15};
    meas[1] = '{ch: 1, n: 12, pat: 32'b101101001011, exp_data: 8'd7};
    meas[2] = '{ch: 3, n: 40, pat: 32'h0,         exp_data: 8'd40};

    sweep[0] = '{sel: 2'd0, exp_data: 8'd15, exp_data3: 8'd15, exp_done3: 1'b1};
    sweep[1] = '{sel: 2'd1, exp_data: 8'd7,  exp_data3: 8'd12, exp_done3: 1'b1};
    sweep[2] = '{sel: 2'd2, exp_data: 8'd5,  exp_data3: 8'd5,  exp_done3: 1'b1};
    sweep[3] = '{sel: 2'd3, exp_data: 8'd40, exp_data3: 8'd0,  exp_done3: 1'b0};

    rst = 1'b1; enable = 1'b0; initialize = 1'b0;
    start = '0; stop = '0; evt = '0; rd_sel = '0;
    tick();
    tick();
    check("reset rd_data", rd_data, 0);
    check("reset rd_sat", rd_sat, 0);
    check("reset rd_done", rd_done, 0);
    check("reset done", done, 0);
    check("reset all_done", all_done, 0);

    rst = 1'b0; enable = 1'b1;
    tick();

    foreach (meas[m]) begin
      run_measure(meas[m].ch, meas[m].n, meas[m].pat);
      check($sformatf("meas ch%0d rd_data", meas[m].ch), rd_data, meas[m].exp_data);
      check($sformatf("meas ch%0d rd_done", meas[m].ch), rd_done, 1);
      check($sformatf("meas ch%0d rd_sat", meas[m].ch), rd_sat, 0);
      check($sformatf("meas ch%0d done", meas[m].ch), done[meas[m].ch], 1);
    end
    check("all_done with ch2 idle", all_done, 0);

    // Channel 2: start+stop together, a start while running, then a start while done.
    start[2] = 1'b1; stop[2] = 1'b1; rd_sel = 2'd2;
    tick();
    start[2] = 1'b0; stop[2] = 1'b0;
    check("ch2 running after start+stop", done[2], 0);
    tick();
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    tick();
    tick();
    stop[2] = 1'b1;
    tick();
    stop[2] = 1'b0;
    check("ch2 cap", rd_data, 5);
    check("ch2 rd_done", rd_done, 1);
    check("all_done", all_done, 1);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    tick();
    tick();
    stop[2] = 1'b1;
    tick();
    stop[2] = 1'b0;
    check("ch2 start in DONE ignored", rd_data, 5);
    check("ch2 still done", done[2], 1);

    for (int i = 0; i < 4; i++) begin
      logic [7:0] prev;
      prev = (i == 0) ? 8'd5 : sweep[i-1].exp_data;
      rd_sel = sweep[i].sel;
      #1;
      check($sformatf("sweep sel%0d before edge", i), rd_data, prev);
      tick();
      check($sformatf("sweep sel%0d rd_data", i), rd_data, sweep[i].exp_data);
      check($sformatf("sweep sel%0d rd_data3", i), rd_data3, sweep[i].exp_data3);
      check($sformatf("sweep sel%0d rd_done3", i), rd_done3, sweep[i].exp_done3);
    end

    initialize = 1'b1;
    tick();
    initialize = 1'b0;
    check("init all_done", all_done, 0);
    check("init done", done, 0);
    check("init cap held", rd_data, 40);
    check("init rd_done", rd_done, 0);

    // Saturation boundary: 255 fits exactly, 300 saturates.
    run_measure(0, 255, 32'h0);
    check("n255 rd_data", rd_data, 255);
    check("n255 rd_sat", rd_sat, 0);
    initialize = 1'b1;
    tick();
    initialize = 1'b0;
    run_measure(0, 300, 32'h0);
    check("n300 rd_data", rd_data, 255);
    check("n300 rd_sat", rd_sat, 1);
    initialize = 1'b1;
    tick();
    initialize = 1'b0;
    check("post-init rd_sat", rd_sat, 0);
    check("post-init rd_data", rd_data, 255);

    // enable low mid-run aborts channel 3 and clears done of channel 0.
    run_measure(0, 3, 32'h0);
    check("ch0 short cap", rd_data, 3);
    start[3] = 1'b1; rd_sel = 2'd3;
    tick();
    start[3] = 1'b0;
    repeat (4) tick();
    enable = 1'b0;
    tick();
    check("enable low done", done, 0);
    enable = 1'b1;
    stop[3] = 1'b1;
    tick();
    stop[3] = 1'b0;
    check("stop after enable low rd_done", rd_done, 0);
    check("stop after enable low rd_data", rd_data, 40);
    rd_sel = 2'd0;
    tick();
    check("cap held through enable low", rd_data, 3);

    // Reset mid-run clears everything.
    start[3] = 1'b1;
    tick();
    start[3] = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst rd_data", rd_data, 0);
    check("rst done", done, 0);
    check("rst all_done", all_done, 0);
    stop[3] = 1'b1; rd_sel = 2'd3;
    tick();
    stop[3] = 1'b0;
    check("rst aborted ch3 rd_data", rd_data, 0);
    check("rst aborted ch3 rd_done", rd_done, 0);
    rd_sel = 2'd0;
    tick();
    check("rst cleared ch0 cap", rd_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
